// File: rtl/byte_pkg.sv
// Shared widths and FSM state type for the byte deserializer.
package byte_pkg;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } deser_state_t;
endpackage

// File: rtl/byte_deserializer.sv
// Serial-to-byte deserializer with framed start marker, output handshake and sticky error flags.
// Optional even-parity ninth bit is enabled by defining PARITY_CHECK_EN.
module byte_deserializer
  import byte_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sin,
  input  logic              sin_valid,
  input  logic              sin_start,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              parity_err,
  input  logic              clear_err
);

  deser_state_t      state, state_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [BYTE_W-1:0] sreg, sreg_nxt;
  logic              done;
  logic [BYTE_W-1:0] done_data;
  logic              drop;
`ifdef PARITY_CHECK_EN
  logic              parity_bad;
  logic              parity_err_q;
`endif

  function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] cur, input logic b);
    return LSB_FIRST ? {b, cur[BYTE_W-1:1]} : {cur[BYTE_W-2:0], b};
  endfunction

  function automatic logic [BYTE_W-1:0] first_bit(input logic b);
    return LSB_FIRST ? {b, {(BYTE_W-1){1'b0}}} : {{(BYTE_W-1){1'b0}}, b};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      sreg  <= sreg_nxt;
    end
  end

  // A qualified start marker restarts the frame from any state.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    sreg_nxt  = sreg;
    done      = 1'b0;
    done_data = sreg;
`ifdef PARITY_CHECK_EN
    parity_bad = 1'b0;
`endif
    if (sin_valid) begin
      if (sin_start) begin
        state_nxt = SHIFT;
        count_nxt = CNT_W'(1);
        sreg_nxt  = first_bit(sin);
      end else begin
        case (state)
          SHIFT: begin
            sreg_nxt  = shift_in(sreg, sin);
            count_nxt = count + CNT_W'(1);
            if (count == CNT_W'(BYTE_W - 1)) begin
`ifdef PARITY_CHECK_EN
              state_nxt = PARITY;
`else
              state_nxt = IDLE;
              done      = 1'b1;
              done_data = sreg_nxt;
`endif
            end
          end
`ifdef PARITY_CHECK_EN
          PARITY: begin
            state_nxt  = IDLE;
            done       = 1'b1;
            done_data  = sreg;
            parity_bad = (sin != ^sreg);
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // A completed byte is dropped only if the held byte is not leaving this cycle.
  assign drop = done && out_valid && !out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (done && !drop) begin
        out_data  <= done_data;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      overrun <= drop ? 1'b1 : (clear_err ? 1'b0 : overrun);
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_bad ? 1'b1 : (clear_err ? 1'b0 : parity_err_q);
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_byte_deserializer.sv
// Directed bench for byte_deserializer: frame-level reference model plus literal spot checks.
module tb_byte_deserializer;
  localparam bit LSB = 1'b1;
`ifdef PARITY_CHECK_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       reset_n, sin, sin_valid, sin_start, out_ready, clear_err;
  logic [7:0] out_data;
  logic       out_valid, overrun, parity_err;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  byte_deserializer #(.LSB_FIRST(LSB)) dut (
    .clk(clk), .reset_n(reset_n), .sin(sin), .sin_valid(sin_valid),
    .sin_start(sin_start), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .parity_err(parity_err),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  // Reference model: received bits stored by arrival index, byte assembled when the frame is full.
  logic [8:0] m_bits, nb_bits;
  int         m_n, nb_n;
  bit         m_act, nb_act, fin, pbad;
  logic [7:0] byt;
  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_perr;

  always_comb begin
    nb_bits = m_bits;
    nb_n    = m_n;
    nb_act  = m_act;
    fin     = 1'b0;
    byt     = 8'h00;
    pbad    = 1'b0;
    if (sin_valid) begin
      if (sin_start) begin
        nb_bits    = '0;
        nb_bits[0] = sin;
        nb_n       = 1;
        nb_act     = 1'b1;
      end else if (m_act) begin
        nb_bits[m_n] = sin;
        nb_n         = m_n + 1;
      end
      if (nb_act && nb_n == FRAME) begin
        fin    = 1'b1;
        nb_act = 1'b0;
        nb_n   = 0;
        for (int i = 0; i < 8; i++) byt[LSB ? i : 7 - i] = nb_bits[i];
        if (FRAME == 9) pbad = (nb_bits[8] != ^byt);
      end
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_bits <= '0; m_n <= 0; m_act <= 1'b0;
      m_data <= 8'h00; m_valid <= 1'b0; m_ovr <= 1'b0; m_perr <= 1'b0;
    end else begin
      m_bits <= nb_bits; m_n <= nb_n; m_act <= nb_act;
      if (fin && !(m_valid && !out_ready)) begin
        m_data  <= byt;
        m_valid <= 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
      m_ovr  <= (fin && m_valid && !out_ready) ? 1'b1 : (clear_err ? 1'b0 : m_ovr);
      m_perr <= pbad ? 1'b1 : (clear_err ? 1'b0 : m_perr);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      n_checks++;
      if (out_data !== m_data || out_valid !== m_valid || overrun !== m_ovr || parity_err !== m_perr)
        $display("FAIL model t=%0t: got data=%h vld=%b ovr=%b perr=%b, want data=%h vld=%b ovr=%b perr=%b",
                 $time, out_data, out_valid, overrun, parity_err, m_data, m_valid, m_ovr, m_perr);
      else
        n_pass++;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic st);
    sin = b; sin_start = st; sin_valid = 1'b1;
    @(posedge clk);
    #1;
    sin = 1'b0; sin_start = 1'b0; sin_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit par_ok, input bit rdy_end,
                           input bit clr_end, input bit gaps);
    logic v;
    for (int i = 0; i < FRAME; i++) begin
      if (i < 8) v = b[LSB ? i : 7 - i];
      else       v = par_ok ? ^b : ~^b;
      if (i == FRAME - 1) begin
        if (rdy_end) out_ready = 1'b1;
        if (clr_end) clear_err = 1'b1;
      end
      send_bit(v, i == 0);
      if (gaps && i != FRAME - 1) idle($urandom_range(0, 2));
    end
    if (rdy_end) out_ready = 1'b0;
    if (clr_end) clear_err = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; sin_start = 1'b0;
    out_ready = 1'b0; clear_err = 1'b0;
    idle(3);
    chk("reset_data", out_data, 8'h00);
    chk("reset_valid", {7'd0, out_valid}, 8'h00);
    chk("reset_overrun", {7'd0, overrun}, 8'h00);
    chk("reset_parity", {7'd0, parity_err}, 8'h00);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    idle(2);

    // Basic byte, one-cycle valid pulse.
    out_ready = 1'b1;
    send_byte(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("a5_data", out_data, 8'hA5);
    chk("a5_valid", {7'd0, out_valid}, 8'h01);
    idle(1);
    chk("a5_valid_fall", {7'd0, out_valid}, 8'h00);

    // Overrun: second byte dropped, held byte kept.
    out_ready = 1'b0;
    send_byte(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovr_data_held", out_data, 8'h3C);
    chk("ovr_set", {7'd0, overrun}, 8'h01);
    clear_err = 1'b1; idle(1); clear_err = 1'b0;
    chk("ovr_cleared", {7'd0, overrun}, 8'h00);

    // Set beats clear in the same cycle.
    send_byte(8'h99, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("ovr_set_wins", {7'd0, overrun}, 8'h01);
    chk("ovr_data_still", out_data, 8'h3C);
    clear_err = 1'b1; idle(1); clear_err = 1'b0;

    // Completion coincident with handshake.
    send_byte(8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hs_data", out_data, 8'h55);
    chk("hs_valid", {7'd0, out_valid}, 8'h01);
    chk("hs_overrun", {7'd0, overrun}, 8'h00);
    out_ready = 1'b1;
    idle(1);
    chk("hs_drained", {7'd0, out_valid}, 8'h00);

    // Aborted partial frame, then a gapped frame.
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_byte(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("abort_data", out_data, 8'hF0);
    chk("abort_valid", {7'd0, out_valid}, 8'h01);
    idle(2);

    // Asynchronous reset mid-frame with a byte pending.
    out_ready = 1'b0;
    send_byte(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_valid", {7'd0, out_valid}, 8'h00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    idle(1);
    chk("no_start_ignored", {7'd0, out_valid}, 8'h00);
    out_ready = 1'b1;
    send_byte(8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_data", out_data, 8'h12);
    chk("post_rst_valid", {7'd0, out_valid}, 8'h01);
    idle(2);

`ifdef PARITY_CHECK_EN
    send_byte(8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("par_bad_data", out_data, 8'h07);
    chk("par_bad_flag", {7'd0, parity_err}, 8'h01);
    clear_err = 1'b1; idle(1); clear_err = 1'b0;
    chk("par_cleared", {7'd0, parity_err}, 8'h00);
    send_byte(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("par_ok_data", out_data, 8'h07);
    chk("par_ok_flag", {7'd0, parity_err}, 8'h00);
`else
    send_byte(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("nopar_data", out_data, 8'h07);
    chk("nopar_flag", {7'd0, parity_err}, 8'h00);
`endif
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
